// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: walks a register range through one register-file read port and
// streams each value over valid/ready. Define REGDUMP_CHECKSUM_EN for a trailing XOR beat.
module regfile_dump_unit #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int READ_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]   rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [XLEN-1:0]   dump_data,
    output logic [ADDR_W-1:0] dump_index,
    output logic              dump_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_e;

`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              dlast_q, dlast_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              capture_s;
`ifdef REGDUMP_CHECKSUM_EN
    logic [XLEN-1:0]   xor_q, xor_d;
    logic              csum_q, csum_d;
`endif

    // Next-state and next-output logic for the dump walk.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        rs_addr_d = rs_addr_q;
        valid_d   = valid_q;
        data_d    = data_q;
        index_d   = index_q;
        dlast_d   = dlast_q;
        capture_s = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        xor_d     = xor_q;
        csum_d    = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_d  = first_reg;
                    last_d = last_reg;
`ifdef REGDUMP_CHECKSUM_EN
                    xor_d  = {XLEN{1'b0}};
                    csum_d = 1'b0;
`endif
                    if (first_reg > last_reg) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_READ;
                        rs_addr_d = first_reg;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (READ_LAT == 0) begin
                    capture_s = 1'b1;
                    state_d   = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                capture_s = 1'b1;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (dump_ready) begin
                    valid_d = 1'b0;
                    dlast_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    // The register walk ends by re-entering HOLD with the checksum beat.
                    if (csum_q) begin
                        state_d = S_DONE;
                    end else if (cur_q == last_q) begin
                        csum_d  = 1'b1;
                        valid_d = 1'b1;
                        data_d  = xor_q;
                        index_d = last_q;
                        dlast_d = 1'b1;
                    end else begin
                        cur_d     = cur_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        rs_addr_d = cur_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_d   = S_READ;
                    end
`else
                    if (cur_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d     = cur_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        rs_addr_d = cur_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_d   = S_READ;
                    end
`endif
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        data_d  = capture_s ? rd_data : data_d;
        index_d = capture_s ? cur_q : index_d;
        valid_d = capture_s ? 1'b1 : valid_d;
        dlast_d = capture_s ? (!CSUM_EN && (cur_q == last_q)) : dlast_d;
`ifdef REGDUMP_CHECKSUM_EN
        xor_d   = capture_s ? (xor_q ^ rd_data) : xor_d;
`endif
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and registered-output storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cur_q     <= {ADDR_W{1'b0}};
            last_q    <= {ADDR_W{1'b0}};
            rs_addr_q <= {ADDR_W{1'b0}};
            valid_q   <= 1'b0;
            data_q    <= {XLEN{1'b0}};
            index_q   <= {ADDR_W{1'b0}};
            dlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            xor_q     <= {XLEN{1'b0}};
            csum_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            rs_addr_q <= rs_addr_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            index_q   <= index_d;
            dlast_q   <= dlast_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
            xor_q     <= xor_d;
            csum_q    <= csum_d;
`endif
        end
    end

    assign rs_addr    = rs_addr_q;
    assign dump_valid = valid_q;
    assign dump_data  = data_q;
    assign dump_index = index_q;
    assign dump_last  = dlast_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// tb_regfile_dump_unit: directed vector table plus hand-written reset-abort sequence
// for regfile_dump_unit with a combinational register-file model.
module tb_regfile_dump_unit;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  rs_addr;
    logic [31:0] rd_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [4:0]  dump_index;
    logic        dump_last;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];
    int tests = 0;
    int fails = 0;

    regfile_dump_unit #(.XLEN(32), .ADDR_W(5), .READ_LAT(0)) dut (
        .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .last_reg(last_reg),
        .rs_addr(rs_addr), .rd_data(rd_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_index(dump_index), .dump_last(dump_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign rd_data = rf[rs_addr];

    typedef struct {
        int          pat;
        logic [4:0]  first;
        logic [4:0]  last;
        int          stall_idx;
        int          stall_len;
        bit          restart;
        int          beats;
        int          cycles;
        logic [31:0] d_first;
        logic [31:0] d_last;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pattern 0: x[i]=i*0x01010101; pattern 1 overlays the named values.
    task automatic load(input int pat);
        for (int i = 0; i < 32; i++) rf[i] = i * 32'h0101_0101;
        if (pat == 1) begin
            rf[5]  = 32'hDEAD_BEEF;
            rf[6]  = 32'h1234_5678;
            rf[7]  = 32'h0000_0000;
            rf[31] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int nb, cyc, stall_left, nregs, idx, exp_beats, exp_cycles;
        bit gd;
        logic [31:0] xr, ed;
        logic el;
        nregs      = (v.first > v.last) ? 0 : int'(v.last) - int'(v.first) + 1;
        exp_beats  = v.beats + ((CS == 1 && nregs > 0) ? 1 : 0);
        exp_cycles = v.cycles + ((CS == 1 && nregs > 0) ? 1 : 0);
        load(v.pat);
        nb = 0; cyc = 0; gd = 1'b0; stall_left = v.stall_len; xr = 32'h0;
        @(negedge clk);
        start = 1'b1; first_reg = v.first; last_reg = v.last; dump_ready = 1'b1;
        @(posedge clk); cyc = 1; #1;
        start = 1'b0;
        while (!gd && cyc < 300) begin
            if (done) begin
                gd = 1'b1;
            end else begin
                @(negedge clk);
                start = (v.restart && nb == 1 && dump_valid);
                if (start) begin
                    first_reg = 5'd0; last_reg = 5'd31;
                end
                if (dump_valid) begin
                    if (int'(dump_index) == v.stall_idx && stall_left > 0) begin
                        dump_ready = 1'b0;
                        stall_left--;
                        chk("stall_hold", {dump_valid, rs_addr, dump_index, dump_data},
                            {1'b1, 5'(v.stall_idx), 5'(v.stall_idx), rf[v.stall_idx]});
                    end else begin
                        dump_ready = 1'b1;
                        if (nb < nregs) begin
                            idx = int'(v.first) + nb;
                            ed  = rf[idx];
                            el  = (CS == 0) && (idx == int'(v.last));
                            xr  = xr ^ ed;
                            if (nb == 0) chk("first_data", dump_data, v.d_first);
                            if (idx == int'(v.last)) chk("last_data", dump_data, v.d_last);
                        end else begin
                            idx = int'(v.last);
                            ed  = xr;
                            el  = 1'b1;
                        end
                        chk("beat", {dump_index, dump_data, dump_last}, {5'(idx), ed, el});
                        nb++;
                    end
                end
                @(posedge clk); cyc++; #1;
            end
        end
        dump_ready = 1'b1;
        chk("got_done", gd, 1);
        chk("beats", nb, exp_beats);
        chk("cycles", cyc, exp_cycles);
        chk("busy_at_done", {busy, dump_valid}, 2'b10);
        @(posedge clk); #1;
        chk("done_pulse", {done, busy, dump_valid}, 3'b000);
    endtask

    initial begin
        int n;
        bit seen;
        // pat, first, last, stall_idx, stall_len, restart, beats, cycles, first data, last data
        vecs[0] = '{1, 5'd5,  5'd7,  -1, 0, 1'b0, 3,  7,  32'hDEAD_BEEF, 32'h0000_0000};
        vecs[1] = '{0, 5'd0,  5'd31, -1, 0, 1'b0, 32, 65, 32'h0000_0000, 32'h1F1F_1F1F};
        vecs[2] = '{1, 5'd5,  5'd7,   6, 5, 1'b0, 3,  12, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[3] = '{1, 5'd9,  5'd3,  -1, 0, 1'b0, 0,  1,  32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{1, 5'd5,  5'd7,  -1, 0, 1'b1, 3,  7,  32'hDEAD_BEEF, 32'h0000_0000};
        vecs[5] = '{1, 5'd31, 5'd31, -1, 0, 1'b0, 1,  3,  32'hFFFF_FFFF, 32'hFFFF_FFFF};

        rst = 1'b0; start = 1'b0; first_reg = 5'd0; last_reg = 5'd0; dump_ready = 1'b1;
        load(0);
        #1;
        chk("reset_state", {rs_addr, dump_valid, dump_data, dump_index, dump_last, busy, done}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", {rs_addr, dump_valid, busy, done}, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset asserted while a beat is held: outputs clear at once and no done follows.
        load(1);
        @(negedge clk);
        start = 1'b1; first_reg = 5'd5; last_reg = 5'd7; dump_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!dump_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_hold", dump_valid, 1);
        rst = 1'b0;
        #1;
        chk("rst_async", {rs_addr, dump_valid, dump_data, dump_index, dump_last, busy, done}, 0);
        @(posedge clk); #1;
        chk("rst_held", {rs_addr, dump_valid, dump_data, dump_index, dump_last, busy, done}, 0);
        @(negedge clk);
        rst = 1'b1; dump_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen = seen | done | busy | dump_valid;
        end
        chk("no_done_after_abort", seen, 0);

        run_vec(vecs[5]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
